// File: rtl/hgcal_input_packer.sv
// Quantizes an unsigned sample stream to Q_W-bit codes and packs N_FEAT codes per frame behind a hold register.
// Optional framing checks (err, drop_cnt, DRAIN state) are enabled by defining HGCAL_PACKER_FRAME_CHECK_EN.
module hgcal_input_packer #(
  parameter int IN_W   = 8,
  parameter int Q_W    = 2,
  parameter int SHIFT  = 5,
  parameter int N_FEAT = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [IN_W-1:0]        s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [N_FEAT*Q_W-1:0]  m_data,
  output logic                   err,
  output logic [7:0]             drop_cnt
);

  localparam int IDX_W   = $clog2(N_FEAT);
  localparam int FRAME_W = N_FEAT * Q_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
  localparam logic [IN_W-1:0]  CODE_MAX = IN_W'((1 << Q_W) - 1);

  // DRAIN is only reachable when the framing check is compiled in.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [FRAME_W-1:0] buf_reg;
  logic [FRAME_W-1:0] frame_with_beat;
  logic [FRAME_W-1:0] m_data_reg;
  logic               m_valid_reg;
  logic [IN_W-1:0]    shifted;
  logic [Q_W-1:0]     code;
  logic               beat, hold_free;
  logic               early_last, missing_last;
  logic               buf_we, load_beat, load_buf, frame_drop;

  assign shifted = s_data >> SHIFT;
  assign code    = (shifted > CODE_MAX) ? CODE_MAX[Q_W-1:0] : shifted[Q_W-1:0];

  assign s_ready   = rst & (state_reg != WAIT);
  assign beat      = s_valid & s_ready;
  assign hold_free = ~m_valid_reg | m_ready;
  assign m_valid   = m_valid_reg;
  assign m_data    = m_data_reg;

  // Buffer contents with the in-flight beat merged in, so a completing frame can bypass the buffer.
  generate
    for (genvar gi = 0; gi < N_FEAT; gi++) begin : g_slot
      assign frame_with_beat[gi*Q_W +: Q_W] =
        (idx_reg == IDX_W'(gi)) ? code : buf_reg[gi*Q_W +: Q_W];
    end
  endgenerate

`ifdef HGCAL_PACKER_FRAME_CHECK_EN
  assign early_last   = s_last & (idx_reg != LAST_IDX);
  assign missing_last = ~s_last & (idx_reg == LAST_IDX);
`else
  assign early_last   = 1'b0;
  assign missing_last = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    buf_we     = 1'b0;
    load_beat  = 1'b0;
    load_buf   = 1'b0;
    frame_drop = 1'b0;
    case (state_reg)
      FILL: begin
        if (beat) begin
          if (early_last) begin
            idx_next   = '0;
            frame_drop = 1'b1;
          end else if (missing_last) begin
            idx_next   = '0;
            frame_drop = 1'b1;
            state_next = DRAIN;
          end else if (idx_reg == LAST_IDX) begin
            idx_next = '0;
            if (hold_free) begin
              load_beat = 1'b1;
            end else begin
              buf_we     = 1'b1;
              state_next = WAIT;
            end
          end else begin
            idx_next = idx_reg + IDX_W'(1);
            buf_we   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (hold_free) begin
          load_buf   = 1'b1;
          state_next = FILL;
        end
      end
      DRAIN: begin
        if (beat && s_last) begin
          state_next = FILL;
          idx_next   = '0;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= FILL;
      idx_reg     <= '0;
      buf_reg     <= '0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (buf_we) buf_reg <= frame_with_beat;
      if (load_beat) begin
        m_data_reg  <= frame_with_beat;
        m_valid_reg <= 1'b1;
      end else if (load_buf) begin
        m_data_reg  <= buf_reg;
        m_valid_reg <= 1'b1;
      end else if (m_ready) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

`ifdef HGCAL_PACKER_FRAME_CHECK_EN
  logic       err_reg;
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_reg      <= 1'b0;
      drop_cnt_reg <= 8'd0;
    end else begin
      err_reg <= frame_drop;
      if (frame_drop && drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign err      = err_reg;
  assign drop_cnt = drop_cnt_reg;
`else
  logic unused_drop;
  assign unused_drop = frame_drop;
  assign err         = 1'b0;
  assign drop_cnt    = 8'd0;
`endif

endmodule

// File: tb/tb_hgcal_input_packer.sv
// Directed bench for hgcal_input_packer: quantization table, back-pressure, streaming and framing checks.
module tb_hgcal_input_packer;
  localparam int IN_W   = 8;
  localparam int Q_W    = 2;
  localparam int N_FEAT = 48;
  localparam int FW     = N_FEAT * Q_W;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_last = 1'b0;
  logic            m_ready = 1'b0;
  logic [IN_W-1:0] s_data = '0;
  logic            s_ready, m_valid, err;
  logic [FW-1:0]   m_data;
  logic [7:0]      drop_cnt;

  always #5 clk = ~clk;

  hgcal_input_packer dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .err      (err),
    .drop_cnt (drop_cnt)
  );

  typedef struct {
    logic [IN_W-1:0] sample;
    logic [Q_W-1:0]  code;
  } qvec_t;

  qvec_t           qtab [8];
  logic [IN_W-1:0] frame_samples [64];
  int              n_checks = 0;
  int              n_fail = 0;
  longint          cycle = 0;
  logic [FW-1:0]   got_q [$];
  longint          got_t [$];
  logic [FW-1:0]   exp_q [$];
  int              ready_low_cnt = 0;
  int              err_cnt = 0;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      got_t.push_back(cycle);
      $display("frame out: cycle %0d m_data %h", cycle, m_data);
    end
  end

  always @(negedge clk) begin
    if (rst && s_valid && !s_ready) ready_low_cnt <= ready_low_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [Q_W-1:0] quant(input logic [IN_W-1:0] d);
    if (d >= 8'd96) return 2'd3;
    if (d >= 8'd64) return 2'd2;
    if (d >= 8'd32) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [FW-1:0] expected_frame();
    logic [FW-1:0] f = '0;
    for (int k = 0; k < N_FEAT; k++) f[k*Q_W +: Q_W] = quant(frame_samples[k]);
    return f;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 64; i++) frame_samples[i] = IN_W'($urandom_range(0, 255));
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [IN_W-1:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!s_ready) begin
      n_fail++;
      $display("FAIL beat_timeout: s_ready got 0 expected 1 within 300 cycles");
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_seq(input int nbeats, input int last_at);
    for (int i = 0; i < nbeats; i++) send_beat(frame_samples[i], i == last_at);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] exp_a, exp_b, exp_f;
    int base_ready, base_err;

    qtab[0] = '{8'd0,   2'd0};
    qtab[1] = '{8'd31,  2'd0};
    qtab[2] = '{8'd32,  2'd1};
    qtab[3] = '{8'd63,  2'd1};
    qtab[4] = '{8'd64,  2'd2};
    qtab[5] = '{8'd95,  2'd2};
    qtab[6] = '{8'd96,  2'd3};
    qtab[7] = '{8'd255, 2'd3};

    // Reset held with a valid beat presented
    rst = 1'b0; s_valid = 1'b1; s_data = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_err", err, 0);
    rst = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    check("rel_s_ready", s_ready, 1);

    // Quantization table applied across one frame
    m_ready = 1'b1;
    for (int i = 0; i < N_FEAT; i++) frame_samples[i] = qtab[i % 8].sample;
    send_seq(N_FEAT, N_FEAT - 1);
    check("quant_latency_m_valid", m_valid, 1);
    for (int k = 0; k < N_FEAT; k++)
      check($sformatf("quant_k%0d", k), m_data[k*Q_W +: Q_W], qtab[k % 8].code);
    check("quant_err", err, 0);
    @(negedge clk);
    check("quant_consumed", m_valid, 0);

    // Reset mid-frame discards the partial frame
    fill_random();
    send_seq(20, -1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_m_valid", m_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    fill_random();
    exp_f = expected_frame();
    send_seq(N_FEAT, N_FEAT - 1);
    check("midrst_frame_valid", m_valid, 1);
    check("midrst_frame_data", m_data, exp_f);
    @(negedge clk);

    // Back-pressure: two frames queued behind m_ready=0
    m_ready = 1'b0;
    fill_random();
    exp_a = expected_frame();
    send_seq(N_FEAT, N_FEAT - 1);
    check("bp_a_valid", m_valid, 1);
    check("bp_a_data", m_data, exp_a);
    fill_random();
    exp_b = expected_frame();
    send_seq(N_FEAT, N_FEAT - 1);
    check("bp_s_ready_low", s_ready, 0);
    check("bp_a_stable", m_data, exp_a);
    repeat (3) @(negedge clk);
    check("bp_s_ready_still_low", s_ready, 0);
    check("bp_a_still_stable", m_data, exp_a);
    got_q.delete(); got_t.delete();
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_out_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check("bp_out_a", got_q[0], exp_a);
      check("bp_out_b", got_q[1], exp_b);
      check("bp_out_gap", got_t[1] - got_t[0], 1);
    end
    check("bp_s_ready_back", s_ready, 1);

    // Continuous streaming of 10 frames
    got_q.delete(); got_t.delete(); exp_q.delete();
    base_ready = ready_low_cnt;
    for (int f = 0; f < 10; f++) begin
      fill_random();
      exp_q.push_back(expected_frame());
      send_seq(N_FEAT, N_FEAT - 1);
    end
    repeat (2) @(negedge clk);
    check("cont_count", got_q.size(), 10);
    check("cont_no_stall", ready_low_cnt - base_ready, 0);
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      check($sformatf("cont_data_%0d", i), got_q[i], exp_q[i]);
      if (i > 0) check($sformatf("cont_gap_%0d", i), got_t[i] - got_t[i-1], N_FEAT);
    end

`ifdef HGCAL_PACKER_FRAME_CHECK_EN
    // Early last on beat 10
    got_q.delete(); got_t.delete();
    fill_random();
    for (int i = 0; i <= 10; i++) send_beat(frame_samples[i], i == 10);
    check("early_err", err, 1);
    check("early_drop_cnt", drop_cnt, 1);
    check("early_m_valid", m_valid, 0);
    @(negedge clk);
    check("early_err_pulse", err, 0);
    fill_random();
    exp_f = expected_frame();
    send_seq(N_FEAT, N_FEAT - 1);
    check("early_next_valid", m_valid, 1);
    check("early_next_data", m_data, exp_f);
    @(negedge clk);

    // Missing last: 50 beats with s_last on beat 49
    got_q.delete(); got_t.delete();
    fill_random();
    for (int i = 0; i < N_FEAT; i++) send_beat(frame_samples[i], 1'b0);
    check("miss_err", err, 1);
    check("miss_drop_cnt", drop_cnt, 2);
    send_beat(frame_samples[48], 1'b0);
    check("miss_err_pulse", err, 0);
    send_beat(frame_samples[49], 1'b1);
    check("miss_no_frame", got_q.size(), 0);
    check("miss_m_valid", m_valid, 0);
    fill_random();
    exp_f = expected_frame();
    send_seq(N_FEAT, N_FEAT - 1);
    check("miss_next_valid", m_valid, 1);
    check("miss_next_data", m_data, exp_f);
    check("miss_drop_final", drop_cnt, 2);
`else
    // Without the check, s_last placement is irrelevant to framing
    base_err = err_cnt;
    fill_random();
    exp_f = expected_frame();
    send_seq(N_FEAT, 10);
    check("nolast_valid", m_valid, 1);
    check("nolast_data", m_data, exp_f);
    @(negedge clk);
    check("nolast_err", err_cnt - base_err, 0);
    check("nolast_drop_cnt", drop_cnt, 0);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
